// File: rtl/nand_busy_watchdog_pkg.sv
// Shared types and constants for the NAND R/B# busy watchdog.
// State encoding, operation classes and default timeout limits.
package nand_wd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FALL = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_FAULT     = 2'd3
    } wd_state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_PROG  = 2'd1,
        OP_ERASE = 2'd2,
        OP_RST   = 2'd3
    } op_kind_e;

    localparam int CNT_W = 24;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    localparam int TWB_MAX_DEF = 10;
    localparam int T_READ_DEF  = 5000;
    localparam int T_PROG_DEF  = 50000;
    localparam int T_ERASE_DEF = 500000;
    localparam int T_RST_DEF   = 50000;

    // Increment that sticks at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nand_busy_watchdog_if.sv
// Command/status bundle between the flash sequencer and the busy watchdog.
interface nand_busy_watchdog_if;
    import nand_wd_pkg::*;

    logic             op_start;
    logic [1:0]       op_kind;
    logic             rb_n;
    logic             clr_fault;
    logic             nandflash_busy_Noresponse;
    logic             op_done;
    logic [CNT_W-1:0] busy_cycles;
    logic             wd_busy;

    modport master (
        output op_start, op_kind, rb_n, clr_fault,
        input  nandflash_busy_Noresponse, op_done, busy_cycles, wd_busy
    );

    modport slave (
        input  op_start, op_kind, rb_n, clr_fault,
        output nandflash_busy_Noresponse, op_done, busy_cycles, wd_busy
    );

endinterface

// File: rtl/nand_busy_watchdog_rb_sync.sv
// Two-flop synchronizer for the raw R/B# pin; resets to the ready level (1).
module nand_rb_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/nand_busy_watchdog.sv
// Watches NAND R/B# after each command: flags a missing busy fall or an
// over-long busy period, and reports the busy duration of good operations.
module nand_busy_watchdog
    import nand_wd_pkg::*;
#(
    parameter int TWB_MAX = TWB_MAX_DEF,
    parameter int T_READ  = T_READ_DEF,
    parameter int T_PROG  = T_PROG_DEF,
    parameter int T_ERASE = T_ERASE_DEF,
    parameter int T_RST   = T_RST_DEF
) (
    input logic               clk,
    input logic               rst,
    nand_busy_watchdog_if.slave bus
);

    localparam logic [CNT_W-1:0] TWB_LAST  = CNT_W'(TWB_MAX - 1);
    localparam logic [CNT_W-1:0] LIM_READ  = CNT_W'(T_READ);
    localparam logic [CNT_W-1:0] LIM_PROG  = CNT_W'(T_PROG);
    localparam logic [CNT_W-1:0] LIM_ERASE = CNT_W'(T_ERASE);
    localparam logic [CNT_W-1:0] LIM_RST   = CNT_W'(T_RST);

    logic rb_s;

    nand_rb_sync u_rb_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rb_n),
        .q   (rb_s)
    );

    wd_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W-1:0] busy_cycles_q, busy_cycles_d;
    logic             op_done_q, op_done_d;
    logic             fault_q, fault_d;
    logic             wd_busy_q, wd_busy_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        limit_d       = limit_q;
        busy_cycles_d = busy_cycles_q;
        op_done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.op_start) begin
                    case (op_kind_e'(bus.op_kind))
                        OP_READ:  limit_d = LIM_READ;
                        OP_PROG:  limit_d = LIM_PROG;
                        OP_ERASE: limit_d = LIM_ERASE;
                        default:  limit_d = LIM_RST;
                    endcase
                    cnt_d   = '0;
                    state_d = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                if (!rb_s) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RISE;
                end else if (cnt_q == TWB_LAST) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_WAIT_RISE: begin
                // Ready wins over a timeout landing on the same edge.
                if (rb_s) begin
                    busy_cycles_d = sat_inc(cnt_q);
                    op_done_d     = 1'b1;
                    state_d       = ST_IDLE;
                end else if (cnt_q == limit_q - 1'b1) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_FAULT: begin
                if (bus.clr_fault) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status flags are registered from the next state so they track state_q exactly.
        fault_d   = (state_d == ST_FAULT);
        wd_busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            limit_q       <= '0;
            busy_cycles_q <= '0;
            op_done_q     <= 1'b0;
            fault_q       <= 1'b0;
            wd_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            limit_q       <= limit_d;
            busy_cycles_q <= busy_cycles_d;
            op_done_q     <= op_done_d;
            fault_q       <= fault_d;
            wd_busy_q     <= wd_busy_d;
        end
    end

    assign bus.nandflash_busy_Noresponse = fault_q;
    assign bus.op_done                   = op_done_q;
    assign bus.busy_cycles               = busy_cycles_q;
    assign bus.wd_busy                   = wd_busy_q;

endmodule

// File: tb/tb_nand_busy_watchdog.sv
// Self-checking bench for nand_busy_watchdog: directed scenarios plus random
// operations, each predicted from the R/B# timing rules with plain arithmetic.
module tb_nand_busy_watchdog;
    import nand_wd_pkg::*;

    localparam int TWB = 10;
    localparam int TR  = 5000;
    localparam int TP  = 1200;
    localparam int TE  = 300;
    localparam int TRS = 100;
    // Edges from R/B# pin change to the FSM acting on it (drive edge + 2 sync flops).
    localparam int SYNC_LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    nand_busy_watchdog_if bus ();

    nand_busy_watchdog #(
        .TWB_MAX (TWB),
        .T_READ  (TR),
        .T_PROG  (TP),
        .T_ERASE (TE),
        .T_RST   (TRS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [23:0] exp_busy = '0;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lim_of(input int kind);
        case (kind)
            0:       return TR;
            1:       return TP;
            2:       return TE;
            default: return TRS;
        endcase
    endfunction

    task automatic check_outs(input string ph, input bit done, input bit flt, input bit busy);
        check({ph, ".op_done"}, {23'd0, bus.op_done}, {23'd0, done});
        check({ph, ".fault"},   {23'd0, bus.nandflash_busy_Noresponse}, {23'd0, flt});
        check({ph, ".wd_busy"}, {23'd0, bus.wd_busy}, {23'd0, busy});
        check({ph, ".busy_cycles"}, bus.busy_cycles, exp_busy);
    endtask

    // One operation: R/B# pin falls j cycles after the start edge and stays low
    // for L cycles (L == 0: never falls). inject pulses op_start and clr_fault
    // while busy; both must be ignored.
    task automatic run_op(input string nm, input int kind, input int j, input int L, input bit inject);
        int lmt;
        int ev;
        int fall;
        int t_end;
        bit flt;
        lmt  = lim_of(kind);
        fall = j + SYNC_LAT;
        if (L == 0 || fall > TWB) begin
            ev  = TWB;
            flt = 1'b1;
        end else if (L > lmt) begin
            ev  = fall + lmt;
            flt = 1'b1;
        end else begin
            ev  = fall + L;
            flt = 1'b0;
        end
        t_end = ev + 3;
        if (L > 0 && j + L + 4 > t_end) t_end = j + L + 4;

        bus.op_kind  = 2'(kind);
        bus.op_start = 1'b1;
        tick();
        bus.op_start = 1'b0;
        for (int t = 0; t <= t_end; t++) begin
            if (!flt && t == ev) exp_busy = 24'(L);
            check_outs($sformatf("%s.t%0d", nm, t), !flt && t == ev, flt && t >= ev,
                       flt ? 1'b1 : (t < ev));
            bus.rb_n      = !(L > 0 && t >= j && t < j + L);
            bus.op_start  = inject && (t == j + 5);
            bus.clr_fault = inject && (t == j + 5);
            bus.op_kind   = 2'($urandom_range(0, 3));
            tick();
        end
        bus.op_start  = 1'b0;
        bus.clr_fault = 1'b0;
        if (flt) begin
            bus.op_start = 1'b1;
            tick();
            bus.op_start = 1'b0;
            check_outs({nm, ".hold"}, 1'b0, 1'b1, 1'b1);
            bus.clr_fault = 1'b1;
            tick();
            bus.clr_fault = 1'b0;
            check_outs({nm, ".clr"}, 1'b0, 1'b0, 1'b0);
        end
        tick();
        tick();
        check_outs({nm, ".idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int kind;
        int j;
        int L;
        int r;
        int lmt;
        bit inj;

        bus.op_start  = 1'b0;
        bus.op_kind   = 2'd0;
        bus.rb_n      = 1'b1;
        bus.clr_fault = 1'b0;
        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        check_outs("post_reset", 1'b0, 1'b0, 1'b0);

        run_op("prog1000",   1, 0, 1000, 1'b0);
        run_op("no_fall",    2, 0, 0,    1'b0);
        run_op("read_tmo",   0, 2, TR + 3, 1'b0);
        run_op("edge_ok",    3, 1, TRS,     1'b0);
        run_op("edge_tmo",   3, 1, TRS + 1, 1'b0);
        run_op("ignore_cmd", 2, 3, 50, 1'b1);
        run_op("late_fall_ok",  3, TWB - SYNC_LAT,     20, 1'b0);
        run_op("late_fall_tmo", 3, TWB - SYNC_LAT + 1, 20, 1'b0);

        // Reset in the middle of a busy period.
        bus.op_kind  = 2'd2;
        bus.op_start = 1'b1;
        tick();
        bus.op_start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            bus.rb_n = !(t >= 2);
            tick();
        end
        check_outs("mid_busy", 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b0;
        #1;
        exp_busy = '0;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0);
        bus.rb_n = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            check_outs($sformatf("rst_release.t%0d", t), 1'b0, 1'b0, 1'b0);
        end

        // op_start on the very first edge after reset release.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        run_op("first_edge", 3, 2, 40, 1'b0);

        for (int n = 0; n < 12; n++) begin
            kind = $urandom_range(0, 3);
            lmt  = lim_of(kind);
            j    = $urandom_range(0, TWB - SYNC_LAT + 1);
            r    = $urandom_range(0, 9);
            if (r == 0) L = 0;
            else if (r == 1) L = lmt + $urandom_range(1, 4);
            else L = $urandom_range(1, (lmt < 400) ? lmt : 400);
            inj = (L >= 6) && (L <= lmt) && (j + SYNC_LAT <= TWB) && ($urandom_range(0, 1) == 1);
            run_op($sformatf("rnd%0d", n), kind, j, L, inj);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
